// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared data memory.
// Port 0 is the CPU data port, port 1 a secondary master (loader / debug).
// Optional feature: define MEM_ARB_LOCK_EN to add lock0/lock1, which let the
// current owner keep the memory for its next access (atomic read-modify-write).
module dmem_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
`ifdef MEM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic          owner, owner_d;
    logic          last_owner, last_owner_d;
    logic          cap_we, cap_we_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [DW-1:0] rdata_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          gnt0_d, gnt1_d, done0_d, done1_d, mem_wr_d, busy_d;
    logic          win;
`ifdef MEM_ARB_LOCK_EN
    logic          lock_hold, lock_hold_d;
`endif

    // State, captured request and registered outputs
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cap_we     <= 1'b0;
            cnt        <= '0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            mem_wr     <= 1'b0;
            busy       <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lock_hold  <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            cap_we     <= cap_we_d;
            cnt        <= cnt_d;
            rdata      <= rdata_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            gnt0       <= gnt0_d;
            gnt1       <= gnt1_d;
            done0      <= done0_d;
            done1      <= done1_d;
            mem_wr     <= mem_wr_d;
            busy       <= busy_d;
`ifdef MEM_ARB_LOCK_EN
            lock_hold  <= lock_hold_d;
`endif
        end
    end

    // Next state, arbitration and next-cycle output values
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        cap_we_d     = cap_we;
        cnt_d        = cnt;
        rdata_d      = rdata;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        mem_wr_d     = 1'b0;
        win          = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        lock_hold_d  = lock_hold;
`endif

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        win = ~last_owner;
                    end else begin
                        win = req1;
                    end
`ifdef MEM_ARB_LOCK_EN
                    // A locked owner keeps the memory while it still requests
                    if (lock_hold && (owner ? req1 : req0)) begin
                        win = owner;
                    end
                    lock_hold_d = 1'b0;
`endif
                    owner_d     = win;
                    cap_we_d    = win ? we1 : we0;
                    mem_addr_d  = win ? addr1 : addr0;
                    mem_wdata_d = win ? wdata1 : wdata0;
                    mem_wr_d    = cap_we_d;
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                gnt0_d = ~owner;
                gnt1_d = owner;
                if (cap_we) begin
                    done0_d = ~owner;
                    done1_d = owner;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                gnt0_d = ~owner;
                gnt1_d = owner;
                if (cnt == '0) begin
                    rdata_d = mem_rdata;
                    done0_d = ~owner;
                    done1_d = owner;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_DONE: begin
`ifdef MEM_ARB_LOCK_EN
                if (owner ? lock1 : lock0) begin
                    lock_hold_d = 1'b1;
                end else begin
                    last_owner_d = owner;
                end
`else
                last_owner_d = owner;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default parameters, RD_LAT=1).
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        nreset;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, done0, gnt1, done1;
    logic [31:0] rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef MEM_ARB_LOCK_EN
    logic        lock0 = 1'b0;
    logic        lock1 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Memory model: one-cycle registered read, written on mem_wr.
    // Unwritten words read back as 0xA5000000 | byte-address-low-bits.
    logic [31:0] mem [0:255];
    bit          mem_valid [0:255];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wr) begin
            mem[mem_addr[7:0]]       <= mem_wdata;
            mem_valid[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= mem_valid[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                              : (32'hA500_0000 | {24'h0, mem_addr[7:0]});
    end

    dmem_arbiter dut (
        .clock     (clock),
        .nreset    (nreset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .done0     (done0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .done1     (done1),
`ifdef MEM_ARB_LOCK_EN
        .lock0     (lock0),
        .lock1     (lock1),
`endif
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves reset asserted for two edges; the next edge sees nreset=1.
    task automatic apply_reset();
        nreset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        step();
        step();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wr, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, mem_wr, busy});
        end
        checks++;
        if (rdata !== 32'h0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h want zeros", rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0004; wdata0 = 32'h0000_0001;
        step();
        checks++;
        if ({mem_wr, gnt0, gnt1, busy} !== 4'b1101 || mem_addr !== 16'h0004 || mem_wdata !== 32'h1) begin
            errors++;
            $display("FAIL wr_access: wr/g0/g1/busy=%b addr=%h wdata=%h want 1101 0004 00000001",
                     {mem_wr, gnt0, gnt1, busy}, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if ({mem_wr, gnt0, done0, done1, rdata} !== {4'b0110, 32'h0}) begin
            errors++;
            $display("FAIL wr_done: wr/g0/d0/d1=%b rdata=%h want 0110 00000000",
                     {mem_wr, gnt0, done0, done1}, rdata);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({busy, gnt0, done0} !== 3'b000) begin
            errors++;
            $display("FAIL wr_idle: busy/g0/d0=%b want 000", {busy, gnt0, done0});
        end
    endtask

    task automatic test_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0004;
        step();
        checks++;
        if ({mem_wr, gnt1, gnt0, done1} !== 4'b0100 || mem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL rd_access: wr/g1/g0/d1=%b addr=%h want 0100 0004", {mem_wr, gnt1, gnt0, done1}, mem_addr);
        end
        step();
        checks++;
        if ({mem_wr, gnt1, done1, busy} !== 4'b0101 || mem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL rd_wait: wr/g1/d1/busy=%b addr=%h want 0101 0004", {mem_wr, gnt1, done1, busy}, mem_addr);
        end
        step();
        checks++;
        if ({mem_wr, gnt1, done1, done0} !== 4'b0110 || rdata !== 32'h0000_0001) begin
            errors++;
            $display("FAIL rd_done: wr/g1/d1/d0=%b rdata=%h want 0110 00000001", {mem_wr, gnt1, done1, done0}, rdata);
        end
        req1 = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [5:0]  obs, exp;
        logic        own;
        logic [31:0] exp_rd;
        int          ndone = 0;
        apply_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0014;
        for (int k = 0; k < 16; k++) begin
            own = ((k / 4) % 2) == 1;
            obs = {busy, gnt1, gnt0, done1, done0, mem_wr};
            case (k % 4)
                0:       exp = 6'b000000;
                1, 2:    exp = {1'b1, own, ~own, 3'b000};
                default: exp = {1'b1, own, ~own, own, ~own, 1'b0};
            endcase
            if (done0 || done1) ndone++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rr_cycle%0d: busy/g1/g0/d1/d0/wr=%b want %b", k, obs, exp);
            end
            if (k % 4 == 3) begin
                exp_rd = own ? 32'hA500_0014 : 32'hA500_0010;
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL rr_rdata%0d: got %h want %h", k / 4, rdata, exp_rd);
                end
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        checks++;
        if (ndone !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_done_count: got %0d busy=%b want 4 busy=0", ndone, busy);
        end
    endtask

    task automatic test_drop_req();
        int nwr = 0;
        int nd  = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0008; wdata0 = 32'h0000_0055;
        step();
        req0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (mem_wr) nwr++;
            if (done0) nd++;
            step();
        end
        checks++;
        if (nwr !== 1 || nd !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_req: mem_wr count=%0d done0 count=%0d busy=%b want 1 1 0", nwr, nd, busy);
        end
        checks++;
        if (mem[8] !== 32'h0000_0055) begin
            errors++;
            $display("FAIL drop_req_mem: got %h want 00000055", mem[8]);
        end
    endtask

    task automatic test_reset_mid_op();
        int nd1 = 0;
        int nd0 = 0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
        step();
        step();
        checks++;
        if ({gnt1, busy, done1} !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid_wait: g1/busy/d1=%b want 110", {gnt1, busy, done1});
        end
        nreset = 1'b0;
        step();
        if (done1) nd1++;
        checks++;
        if ({gnt1, done1, mem_wr, busy} !== 4'b0000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_clear: g1/d1/wr/busy=%b rdata=%h want 0000 00000000",
                     {gnt1, done1, mem_wr, busy}, rdata);
        end
        nreset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0014;
        step();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_first: g0/g1=%b want 10", {gnt0, gnt1});
        end
        req1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done1) nd1++;
            if (done0) begin
                nd0++;
                req0 = 1'b0;
                checks++;
                if (rdata !== 32'hA500_0014) begin
                    errors++;
                    $display("FAIL rst_mid_rdata: got %h want a5000014", rdata);
                end
            end
            step();
        end
        checks++;
        if (nd0 !== 1 || nd1 !== 0) begin
            errors++;
            $display("FAIL rst_mid_dones: done0=%0d done1=%0d want 1 0", nd0, nd1);
        end
    endtask

    task automatic test_lock();
        logic exp_own [3];
        logic own;
`ifdef MEM_ARB_LOCK_EN
        exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b1;
`else
        exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0;
`endif
        apply_reset();
`ifdef MEM_ARB_LOCK_EN
        lock0 = 1'b1;
`endif
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 32'h0000_00A0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0024; wdata1 = 32'h0000_00B1;
        for (int k = 0; k < 9; k++) begin
            own = exp_own[k / 3];
            if (k % 3 == 1) begin
                checks++;
                if ({gnt1, gnt0, mem_wr} !== {own, ~own, 1'b1}) begin
                    errors++;
                    $display("FAIL lock_grant%0d: g1/g0/wr=%b want %b", k / 3, {gnt1, gnt0, mem_wr}, {own, ~own, 1'b1});
                end
`ifdef MEM_ARB_LOCK_EN
                if (k == 4) lock0 = 1'b0;
`endif
            end else if (k % 3 == 2) begin
                checks++;
                if ({done1, done0} !== {own, ~own}) begin
                    errors++;
                    $display("FAIL lock_done%0d: d1/d0=%b want %b", k / 3, {done1, done0}, {own, ~own});
                end
            end
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_drop_req();
        test_reset_mid_op();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
